// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter pipeline.
package pc_pkg;

    typedef enum logic [1:0] {RD_NONE, RD_EXC, RD_ARITH, RD_RET} redirect_e;

    localparam logic [63:0] PC_RESET_VAL = 64'h0;

    // Byte step for a sequential advance; compressed stepping only exists with C support.
    function automatic logic [2:0] pc_step(input logic compressed, input logic c_ext);
        return (c_ext && compressed) ? 3'd2 : 3'd4;
    endfunction

    // Without C support every target must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] lsbs, input logic c_ext);
        return !c_ext && lsbs[1];
    endfunction

endpackage

// File: rtl/pc_delay_line.sv
// Shift register of delayed PCs with per-stage valid bits, hold and flush.
module pc_delay_line #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 2,
    parameter logic [XLEN-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [XLEN-1:0]       shift_data,
    input  logic                  vld_in,
    input  logic                  hold,
    input  logic                  flush,
    output logic [DEPTH*XLEN-1:0] pc_d,
    output logic [DEPTH-1:0]      pc_vld
);

    logic [XLEN-1:0] addr_pn [DEPTH];
    logic [DEPTH-1:0] vld_pn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) addr_pn[k] <= RESET_VAL;
        end else if (!hold) begin
            addr_pn[0] <= shift_data;
            for (int k = 1; k < DEPTH; k++) addr_pn[k] <= addr_pn[k-1];
        end
    end

    // A flush kills every valid even while the addresses are frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pn <= '0;
        end else if (flush) begin
            vld_pn <= '0;
        end else if (!hold) begin
            vld_pn[0] <= vld_in;
            for (int k = 1; k < DEPTH; k++) vld_pn[k] <= vld_pn[k-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_pack
        assign pc_d[g*XLEN +: XLEN] = addr_pn[g];
    end

    assign pc_vld = vld_pn;

endmodule

// File: rtl/pc_pipe.sv
// Program-counter generator: next-PC selection, redirect/misalign flags and delayed-PC line.
module pc_pipe
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 2,
    parameter logic [XLEN-1:0] RESET_VAL = XLEN'(PC_RESET_VAL),
    parameter int              C_EXT     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  stall_i,
    input  logic                  conflict_i,
    input  logic                  incr_pc_i,
    input  logic                  compressed_i,
    input  logic                  exception_i,
    input  logic                  ret_i,
    input  logic                  load_arith_i,
    input  logic [XLEN-1:0]       arith_out_i,
    input  logic [XLEN-1:0]       mtvec_i,
    input  logic [XLEN-1:0]       mepc_i,
    output logic [XLEN-1:0]       pc_o,
    output logic [DEPTH*XLEN-1:0] pc_d_o,
    output logic [DEPTH-1:0]      pc_vld_o,
    output logic                  redirect_o,
    output logic                  misalign_o,
    output logic [XLEN-1:0]       misalign_addr_o
);

    localparam logic C_EXT_B = (C_EXT != 0);

    redirect_e       cause;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_p0;
    logic [XLEN-1:0] pc_next;
    logic            misalign;
    logic            accept;
    logic            vld_in_p0;
    logic            redirect_p0;
    logic            misalign_p0;
    logic [XLEN-1:0] misalign_addr_p0;

    always_comb begin
        cause  = RD_NONE;
        target = pc_p0;
        if (exception_i) begin
            cause  = RD_EXC;
            target = {mtvec_i[XLEN-1:2], 2'b00};
        end else if (load_arith_i) begin
            cause  = RD_ARITH;
            target = {arith_out_i[XLEN-1:1], 1'b0};
        end else if (ret_i) begin
            cause  = RD_RET;
            target = mepc_i;
        end
    end

    // Trap vectors are forced aligned, so only jump and return targets can be rejected.
    assign misalign  = ((cause == RD_ARITH) || (cause == RD_RET)) && is_misaligned(target[1:0], C_EXT_B);
    assign accept    = (cause != RD_NONE) && !misalign;
    assign vld_in_p0 = !(stall_i || accept || misalign);

    always_comb begin
        pc_next = pc_p0;
        if (accept) begin
            pc_next = target;
        end else if (!misalign && !stall_i && !conflict_i && incr_pc_i) begin
            pc_next = pc_p0 + XLEN'(pc_step(compressed_i, C_EXT_B));
        end
    end

    // Stage p0: fetch PC and single-cycle status flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_p0            <= RESET_VAL;
            redirect_p0      <= 1'b0;
            misalign_p0      <= 1'b0;
            misalign_addr_p0 <= '0;
        end else begin
            pc_p0       <= pc_next;
            redirect_p0 <= accept;
            misalign_p0 <= misalign;
            if (misalign) misalign_addr_p0 <= target;
        end
    end

    pc_delay_line #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .RESET_VAL (RESET_VAL)
    ) u_delay_line (
        .clk        (clk_i),
        .rst_n      (rst_n_i),
        .shift_data (pc_p0),
        .vld_in     (vld_in_p0),
        .hold       (conflict_i),
        .flush      (exception_i),
        .pc_d       (pc_d_o),
        .pc_vld     (pc_vld_o)
    );

    assign pc_o            = pc_p0;
    assign redirect_o      = redirect_p0;
    assign misalign_o      = misalign_p0;
    assign misalign_addr_o = misalign_addr_p0;

endmodule

// File: tb/tb_pc_pipe.sv
// Directed bench for pc_pipe: one instance with C support, one without, sharing all inputs.
module tb_pc_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, conflict = 1'b0, incr = 1'b0, compressed = 1'b0;
    logic        exception = 1'b0, ret = 1'b0, load_arith = 1'b0;
    logic [31:0] arith_out = '0, mtvec = '0, mepc = '0;

    logic [31:0] pc_c, misa_c, pc_n, misa_n;
    logic [63:0] pcd_c, pcd_n;
    logic [1:0]  vld_c, vld_n;
    logic        rd_c, mis_c, rd_n, mis_n;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_pipe #(.XLEN(32), .DEPTH(2), .RESET_VAL(32'h0), .C_EXT(1)) dut_c (
        .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .conflict_i(conflict),
        .incr_pc_i(incr), .compressed_i(compressed), .exception_i(exception),
        .ret_i(ret), .load_arith_i(load_arith), .arith_out_i(arith_out),
        .mtvec_i(mtvec), .mepc_i(mepc), .pc_o(pc_c), .pc_d_o(pcd_c),
        .pc_vld_o(vld_c), .redirect_o(rd_c), .misalign_o(mis_c), .misalign_addr_o(misa_c)
    );

    pc_pipe #(.XLEN(32), .DEPTH(2), .RESET_VAL(32'h0), .C_EXT(0)) dut_n (
        .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .conflict_i(conflict),
        .incr_pc_i(incr), .compressed_i(compressed), .exception_i(exception),
        .ret_i(ret), .load_arith_i(load_arith), .arith_out_i(arith_out),
        .mtvec_i(mtvec), .mepc_i(mepc), .pc_o(pc_n), .pc_d_o(pcd_n),
        .pc_vld_o(vld_n), .redirect_o(rd_n), .misalign_o(mis_n), .misalign_addr_o(misa_n)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stall = 0; conflict = 0; incr = 0; compressed = 0;
        exception = 0; ret = 0; load_arith = 0;
        arith_out = '0; mtvec = '0; mepc = '0;
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc_c !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_c, 32'h0); end
        checks++; if (pcd_c !== 64'h0) begin failures++; $display("FAIL reset_pcd got=%h exp=%h", pcd_c, 64'h0); end
        checks++; if (vld_c !== 2'b00) begin failures++; $display("FAIL reset_vld got=%b exp=%b", vld_c, 2'b00); end
        checks++; if (rd_c !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%b exp=0", rd_c); end
        checks++; if (mis_n !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", mis_n); end
        checks++; if (misa_n !== 32'h0) begin failures++; $display("FAIL reset_misaddr got=%h exp=%h", misa_n, 32'h0); end
    endtask

    task automatic test_incr();
        do_reset();
        incr = 1;
        step();
        checks++; if (pc_c !== 32'h4) begin failures++; $display("FAIL incr_pc1 got=%h exp=%h", pc_c, 32'h4); end
        checks++; if (pcd_c[31:0] !== 32'h0) begin failures++; $display("FAIL incr_s0_1 got=%h exp=%h", pcd_c[31:0], 32'h0); end
        checks++; if (vld_c !== 2'b01) begin failures++; $display("FAIL incr_vld1 got=%b exp=%b", vld_c, 2'b01); end
        step();
        checks++; if (pc_c !== 32'h8) begin failures++; $display("FAIL incr_pc2 got=%h exp=%h", pc_c, 32'h8); end
        checks++; if (pcd_c !== {32'h0, 32'h4}) begin failures++; $display("FAIL incr_pcd2 got=%h exp=%h", pcd_c, {32'h0, 32'h4}); end
        checks++; if (vld_c !== 2'b11) begin failures++; $display("FAIL incr_vld2 got=%b exp=%b", vld_c, 2'b11); end
        step();
        checks++; if (pc_c !== 32'hC) begin failures++; $display("FAIL incr_pc3 got=%h exp=%h", pc_c, 32'hC); end
        step();
        checks++; if (pc_c !== 32'h10) begin failures++; $display("FAIL incr_pc4 got=%h exp=%h", pc_c, 32'h10); end
        checks++; if (pcd_c !== {32'h8, 32'hC}) begin failures++; $display("FAIL incr_pcd4 got=%h exp=%h", pcd_c, {32'h8, 32'hC}); end
        checks++; if (pc_n !== 32'h10) begin failures++; $display("FAIL incr_pc4_noc got=%h exp=%h", pc_n, 32'h10); end
        incr = 0;
    endtask

    task automatic test_compressed();
        do_reset();
        incr = 1; compressed = 1;
        step();
        checks++; if (pc_c !== 32'h2) begin failures++; $display("FAIL comp_pc1 got=%h exp=%h", pc_c, 32'h2); end
        checks++; if (pc_n !== 32'h4) begin failures++; $display("FAIL comp_ignored1 got=%h exp=%h", pc_n, 32'h4); end
        step();
        checks++; if (pc_c !== 32'h4) begin failures++; $display("FAIL comp_pc2 got=%h exp=%h", pc_c, 32'h4); end
        checks++; if (pc_n !== 32'h8) begin failures++; $display("FAIL comp_ignored2 got=%h exp=%h", pc_n, 32'h8); end
        compressed = 0;
        step();
        checks++; if (pc_c !== 32'h8) begin failures++; $display("FAIL comp_pc3 got=%h exp=%h", pc_c, 32'h8); end
        incr = 0; load_arith = 1; arith_out = 32'hFFFF_FFFC;
        step();
        checks++; if (pc_c !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_load got=%h exp=%h", pc_c, 32'hFFFF_FFFC); end
        checks++; if (rd_c !== 1'b1) begin failures++; $display("FAIL wrap_redirect got=%b exp=1", rd_c); end
        load_arith = 0; incr = 1;
        step();
        checks++; if (pc_c !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", pc_c, 32'h0); end
        checks++; if (rd_c !== 1'b0) begin failures++; $display("FAIL wrap_redirect_clr got=%b exp=0", rd_c); end
        checks++; if (pc_n !== 32'h0) begin failures++; $display("FAIL wrap_pc_noc got=%h exp=%h", pc_n, 32'h0); end
        incr = 0;
    endtask

    task automatic test_jump();
        do_reset();
        incr = 1;
        step(); step();
        load_arith = 1; arith_out = 32'h101;
        step();
        checks++; if (pc_c !== 32'h100) begin failures++; $display("FAIL jump_pc got=%h exp=%h", pc_c, 32'h100); end
        checks++; if (rd_c !== 1'b1) begin failures++; $display("FAIL jump_redirect got=%b exp=1", rd_c); end
        checks++; if (pcd_c !== {32'h4, 32'h8}) begin failures++; $display("FAIL jump_pcd got=%h exp=%h", pcd_c, {32'h4, 32'h8}); end
        checks++; if (vld_c !== 2'b10) begin failures++; $display("FAIL jump_vld got=%b exp=%b", vld_c, 2'b10); end
        load_arith = 0; incr = 0;
        step();
        checks++; if (rd_c !== 1'b0) begin failures++; $display("FAIL jump_pulse got=%b exp=0", rd_c); end
        checks++; if (pc_c !== 32'h100) begin failures++; $display("FAIL jump_hold got=%h exp=%h", pc_c, 32'h100); end
    endtask

    task automatic test_misalign();
        do_reset();
        incr = 1;
        step(); step();
        load_arith = 1; arith_out = 32'h102;
        step();
        checks++; if (pc_n !== 32'h8) begin failures++; $display("FAIL mis_pc_hold got=%h exp=%h", pc_n, 32'h8); end
        checks++; if (rd_n !== 1'b0) begin failures++; $display("FAIL mis_redirect got=%b exp=0", rd_n); end
        checks++; if (mis_n !== 1'b1) begin failures++; $display("FAIL mis_pulse got=%b exp=1", mis_n); end
        checks++; if (misa_n !== 32'h102) begin failures++; $display("FAIL mis_addr got=%h exp=%h", misa_n, 32'h102); end
        checks++; if (vld_n !== 2'b10) begin failures++; $display("FAIL mis_vld got=%b exp=%b", vld_n, 2'b10); end
        checks++; if (pcd_n[31:0] !== 32'h8) begin failures++; $display("FAIL mis_s0 got=%h exp=%h", pcd_n[31:0], 32'h8); end
        checks++; if (pc_c !== 32'h102) begin failures++; $display("FAIL mis_cext_ok got=%h exp=%h", pc_c, 32'h102); end
        checks++; if (mis_c !== 1'b0) begin failures++; $display("FAIL mis_cext_flag got=%b exp=0", mis_c); end
        load_arith = 0; incr = 0;
        step();
        checks++; if (mis_n !== 1'b0) begin failures++; $display("FAIL mis_one_cycle got=%b exp=0", mis_n); end
        checks++; if (misa_n !== 32'h102) begin failures++; $display("FAIL mis_addr_held got=%h exp=%h", misa_n, 32'h102); end
        ret = 1; mepc = 32'h10A;
        step();
        checks++; if (mis_n !== 1'b1) begin failures++; $display("FAIL ret_mis_pulse got=%b exp=1", mis_n); end
        checks++; if (misa_n !== 32'h10A) begin failures++; $display("FAIL ret_mis_addr got=%h exp=%h", misa_n, 32'h10A); end
        checks++; if (pc_n !== 32'h8) begin failures++; $display("FAIL ret_mis_hold got=%h exp=%h", pc_n, 32'h8); end
        checks++; if (pc_c !== 32'h10A) begin failures++; $display("FAIL ret_cext got=%h exp=%h", pc_c, 32'h10A); end
        ret = 0;
    endtask

    task automatic test_conflict_exception();
        do_reset();
        incr = 1;
        step(); step();
        conflict = 1; exception = 1; mtvec = 32'h203;
        step();
        checks++; if (pc_c !== 32'h200) begin failures++; $display("FAIL exc_pc got=%h exp=%h", pc_c, 32'h200); end
        checks++; if (pcd_c !== {32'h0, 32'h4}) begin failures++; $display("FAIL exc_pcd_frozen got=%h exp=%h", pcd_c, {32'h0, 32'h4}); end
        checks++; if (vld_c !== 2'b00) begin failures++; $display("FAIL exc_vld got=%b exp=%b", vld_c, 2'b00); end
        checks++; if (rd_c !== 1'b1) begin failures++; $display("FAIL exc_redirect got=%b exp=1", rd_c); end
        exception = 0;
        step();
        checks++; if (pc_c !== 32'h200) begin failures++; $display("FAIL conflict_hold got=%h exp=%h", pc_c, 32'h200); end
        checks++; if (rd_c !== 1'b0) begin failures++; $display("FAIL conflict_rd got=%b exp=0", rd_c); end
        ret = 1; mepc = 32'h300;
        step();
        checks++; if (pc_c !== 32'h300) begin failures++; $display("FAIL conflict_ret got=%h exp=%h", pc_c, 32'h300); end
        checks++; if (pcd_c !== {32'h0, 32'h4}) begin failures++; $display("FAIL conflict_ret_pcd got=%h exp=%h", pcd_c, {32'h0, 32'h4}); end
        ret = 0; conflict = 0; incr = 0;
    endtask

    task automatic test_stall();
        do_reset();
        incr = 1;
        step(); step();
        stall = 1;
        step();
        checks++; if (pc_c !== 32'h8) begin failures++; $display("FAIL stall_pc1 got=%h exp=%h", pc_c, 32'h8); end
        checks++; if (vld_c !== 2'b10) begin failures++; $display("FAIL stall_vld1 got=%b exp=%b", vld_c, 2'b10); end
        checks++; if (pcd_c !== {32'h4, 32'h8}) begin failures++; $display("FAIL stall_pcd1 got=%h exp=%h", pcd_c, {32'h4, 32'h8}); end
        step();
        checks++; if (vld_c !== 2'b00) begin failures++; $display("FAIL stall_vld2 got=%b exp=%b", vld_c, 2'b00); end
        step();
        checks++; if (pc_c !== 32'h8) begin failures++; $display("FAIL stall_pc3 got=%h exp=%h", pc_c, 32'h8); end
        checks++; if (vld_c !== 2'b00) begin failures++; $display("FAIL stall_vld3 got=%b exp=%b", vld_c, 2'b00); end
        #2 rst_n = 0;
        #1;
        checks++; if (pc_c !== 32'h0) begin failures++; $display("FAIL stall_rst_pc got=%h exp=%h", pc_c, 32'h0); end
        checks++; if (pcd_c !== 64'h0) begin failures++; $display("FAIL stall_rst_pcd got=%h exp=%h", pcd_c, 64'h0); end
        stall = 0; incr = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        incr = 1;
        step(); step();
        load_arith = 1; arith_out = 32'h106;
        step();
        checks++; if (rd_c !== 1'b1) begin failures++; $display("FAIL ar_pre_redirect got=%b exp=1", rd_c); end
        checks++; if (mis_n !== 1'b1) begin failures++; $display("FAIL ar_pre_mis got=%b exp=1", mis_n); end
        #3 rst_n = 0;
        #1;
        checks++; if (rd_c !== 1'b0) begin failures++; $display("FAIL ar_redirect got=%b exp=0", rd_c); end
        checks++; if (mis_n !== 1'b0) begin failures++; $display("FAIL ar_mis got=%b exp=0", mis_n); end
        checks++; if (misa_n !== 32'h0) begin failures++; $display("FAIL ar_misaddr got=%h exp=%h", misa_n, 32'h0); end
        checks++; if (pc_c !== 32'h0) begin failures++; $display("FAIL ar_pc got=%h exp=%h", pc_c, 32'h0); end
        checks++; if (vld_n !== 2'b00) begin failures++; $display("FAIL ar_vld got=%b exp=%b", vld_n, 2'b00); end
        load_arith = 0; incr = 0;
    endtask

    initial begin
        test_reset();
        test_incr();
        test_compressed();
        test_jump();
        test_misalign();
        test_conflict_exception();
        test_stall();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_pipe.md
# pc_pipe

Parametrised program-counter generator with a configurable delayed-PC pipeline, compressed-instruction (+2) stepping, per-stage valid tracking and misaligned-target detection. It sits between the core control logic and fetch. It supplies the fetch address and a delayed copy of the PC for each downstream pipeline stage, so decode, execute and trap logic can recover the PC of the instruction they hold.

## Interface
- XLEN, 32, PC and address width
- DEPTH, 2, number of delayed-PC stages (≥1)
- RESET_VAL, `PC_RESET_VAL`, reset value of the PC and of every delayed stage
- C_EXT, 1, 1 = 2-byte alignment and compressed stepping allowed; 0 = 4-byte alignment only, `compressed_i` ignored

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_n_i  in  1  reset, asynchronous and active-low
- stall_i  in  1  hold the PC; insert a bubble into stage 0
- conflict_i  in  1  hold the PC and freeze all delayed stages (addresses and valids)
- incr_pc_i  in  1  advance the PC
- compressed_i  in  1  step is +2 when C_EXT=1; otherwise +4
- exception_i  in  1  trap redirect to `{mtvec_i[XLEN-1:2],2'b00}`; flushes all stages
- ret_i  in  1  return redirect to `mepc_i`
- load_arith_i  in  1  jump/branch redirect to `arith_out_i`
- arith_out_i  in  XLEN  jump/branch target
- mtvec_i  in  XLEN  trap vector
- mepc_i  in  XLEN  return address
- pc_o  out  XLEN  current fetch PC
- pc_d_o  out  DEPTH*XLEN  delayed PCs; stage k is at `[k*XLEN +: XLEN]`
- pc_vld_o  out  DEPTH  valid bit per delayed stage
- redirect_o  out  1  high for the cycle in which `pc_o` first shows a redirect target
- misalign_o  out  1  one-cycle pulse: a rejected misaligned target
- misalign_addr_o  out  XLEN  offending target, held until the next misalign

## Operation
- Next-PC priority:
  1. exception
  2. load_arith
  3. ret
  4. stall or conflict → hold
  5. incr → `pc + step`
  6. otherwise hold
- Arithmetic: `pc + 2` or `pc + 4` modulo 2^XLEN. Wrap from all-ones to 0 is silent.
- `arith_out_i` bit 0 is always cleared before use.
- The mtvec target always has its low two bits cleared.
- Misaligned target: a load_arith or ret target is misaligned when C_EXT=0 and bit 1 is set.
  - The PC holds; `redirect_o` stays low.
  - `misalign_o` pulses the next cycle and `misalign_addr_o` captures the target.
  - Stage 0 receives a bubble.
- Delay line, when conflict_i=0:
  - stage 0 ← pc_q; stage k ← stage k-1.
  - Stage-0 incoming valid = !(stall_i | accepted redirect | misalign).
- exception_i clears every valid bit on the edge, regardless of conflict_i. Addresses shift or hold as usual.
- conflict_i=1 with load_arith or ret: the PC still redirects; stages and valids hold.
- After reset, stage valids fill one per cycle of unstalled increment.

## Timing
- Reset values:
  - pc_o and all pc_d_o stages = RESET_VAL
  - pc_vld_o = 0, redirect_o = 0, misalign_o = 0, misalign_addr_o = 0
- Asserting rst_n_i mid-operation clears all of the above immediately; no partial redirect survives.
- Latency:
  - Control input in cycle t → pc_o updated at t+1.
  - Stage k shows pc_o's value from t-k-1 when no conflict occurs.
- redirect_o and misalign_o are registered pulses. Each is high exactly one cycle.
- No handshake; all inputs are sampled every cycle.

## Structure
- pc_pkg holds:
  - the `redirect_e` enum {RD_NONE, RD_EXC, RD_ARITH, RD_RET}
  - the `pc_step()` function for the step value
  - the `is_misaligned()` function
- One sub-module, `pc_delay_line`, parametrised by XLEN and DEPTH. It takes shift data, valid in, hold (conflict) and flush (exception).
- The top level contains the next-PC mux, the misalign register and the redirect register.

## Test plan
- Reset with RESET_VAL=0, then incr_pc_i=1 for 4 cycles → pc_o 0,4,8,C,10; stage 0 = 0 then 4; pc_vld_o = 01 then 11.
- C_EXT=1, compressed_i=1 for 2 cycles, then 0 → pc_o 0,2,4,8. Starting from pc=FFFF_FFFC with incr → pc wraps to 0.
- At pc=8, load_arith_i with arith_out_i=0x101 → pc_o=0x100 and redirect_o=1 next cycle; stage 0 gets 8 with valid=0.
- C_EXT=0, load_arith_i with target 0x102 → pc holds; misalign_o pulses; misalign_addr_o=0x102.
- conflict_i and exception_i together with mtvec_i=0x203 → pc_o=0x200; stage addresses unchanged; pc_vld_o=00.
- stall_i held for 3 cycles → pc_o constant; bubbles (valid=0) propagate through every stage; asserting rst_n_i low mid-stall → all outputs return to their reset values asynchronously.
